// File: rtl/fir_addr_seq_pkg.sv
// rtl/fir_addr_seq_pkg.sv - shared definitions for the FIR address sequencer
// Holds the sequencer state encodings, the default geometry and the
// {bank,tap} address field widths used by the sequencer and its tap counter.
package fir_addr_seq_pkg;

  localparam int FIR_TAPS     = 10;
  localparam int FIR_NUM_BANK = 4;

  // Address layout: tap in [3:0], bank in [5:4]
  localparam int TAP_W  = 4;
  localparam int BANK_W = 2;
  localparam int ADDR_W = TAP_W + BANK_W;

  typedef enum logic [2:0] {
    FIR_SEQ_IDLE      = 3'd0,
    FIR_SEQ_LOAD      = 3'd1,
    FIR_SEQ_LOAD_TAIL = 3'd2,
    FIR_SEQ_READ      = 3'd3,
    FIR_SEQ_DONE      = 3'd4
  } seq_state_t;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [BANK_W-1:0] bank,
                                                  input logic [TAP_W-1:0]  tap);
    return {bank, tap};
  endfunction

endpackage

// File: rtl/fir_tap_cnt.sv
// rtl/fir_tap_cnt.sv - tap/bank counter shared by the load and read sweeps
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clr              tap <= 0, bank <= 0 (unless bank_ld)
//   inc              advance tap; tap wraps to 0 with bank+1 (bank wraps too)
//   bank_ld, bank_in load bank (takes priority over clr/inc on the bank field)
//   tap, bank        current count
//   last_tap         tap == P_TAPS-1
//   last_word        last tap of the last bank
// Holds its value when neither clr nor inc is asserted.
module fir_tap_cnt
  import fir_addr_seq_pkg::*;
#(
  parameter int P_TAPS     = FIR_TAPS,
  parameter int P_NUM_BANK = FIR_NUM_BANK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic              bank_ld,
  input  logic [BANK_W-1:0] bank_in,
  output logic [TAP_W-1:0]  tap,
  output logic [BANK_W-1:0] bank,
  output logic              last_tap,
  output logic              last_word
);

  logic last_bank;

  assign last_tap  = (tap == TAP_W'(P_TAPS - 1));
  assign last_bank = (bank == BANK_W'(P_NUM_BANK - 1));
  assign last_word = last_tap & last_bank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap  <= '0;
      bank <= '0;
    end else begin
      if (clr)
        tap <= '0;
      else if (inc)
        tap <= last_tap ? '0 : tap + 1'b1;

      if (bank_ld)
        bank <= bank_in;
      else if (clr)
        bank <= '0;
      else if (inc && last_tap)
        bank <= last_bank ? '0 : bank + 1'b1;
    end
  end

endmodule

// File: rtl/fir_addr_seq.sv
// rtl/fir_addr_seq.sv - coefficient-load / sample-read address sequencer for the FIR FSM
// Ports:
//   iClk12M, iRsn                 clock, asynchronous active-low reset
//   iEnSample600k, iBankSel       sample strobe and bank for the read sweep
//   iCoeffLoadReq                 start a full coefficient load
//   iCoeffVld, iCoeffDt, oCoeffRdy host coefficient stream
//   oCoeffUpdateFlag, oMemRdFlag  sweep flags to the FSM (never both high)
//   oAddrRam, oWtDtRam            {bank,tap} address and write data
//   oSampleDone, oOverrun         read sweep complete / strobe dropped pulses
//   oDropCnt                      dropped-strobe count
// Build option FIR_SEQ_DROP_CNT_EN: when defined, oDropCnt is a saturating
// count of dropped strobes; otherwise it is tied to zero.
module fir_addr_seq
  import fir_addr_seq_pkg::*;
#(
  parameter int P_TAPS     = FIR_TAPS,
  parameter int P_NUM_BANK = FIR_NUM_BANK,
  parameter int P_DW       = 16
) (
  input  logic              iClk12M,
  input  logic              iRsn,
  input  logic              iEnSample600k,
  input  logic [BANK_W-1:0] iBankSel,
  input  logic              iCoeffLoadReq,
  input  logic              iCoeffVld,
  input  logic [P_DW-1:0]   iCoeffDt,
  output logic              oCoeffRdy,
  output logic              oCoeffUpdateFlag,
  output logic              oMemRdFlag,
  output logic [ADDR_W-1:0] oAddrRam,
  output logic [P_DW-1:0]   oWtDtRam,
  output logic              oSampleDone,
  output logic              oOverrun,
  output logic [7:0]        oDropCnt
);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [P_DW-1:0]   wtdt_q, wtdt_d;
  logic              upd_q, upd_d, rd_q, rd_d, rdy_q, rdy_d;
  logic              done_q, done_d, ovr_q, ovr_d;
  logic              pending_q, pending_d, prime_q, prime_d;
  logic              drop;

  logic              cnt_clr, cnt_inc, cnt_bank_ld;
  logic [TAP_W-1:0]  cnt_tap;
  logic [BANK_W-1:0] cnt_bank;
  logic              cnt_last_tap, cnt_last_word;

  fir_tap_cnt #(.P_TAPS(P_TAPS), .P_NUM_BANK(P_NUM_BANK)) u_cnt (
    .clk       (iClk12M),
    .rst_n     (iRsn),
    .clr       (cnt_clr),
    .inc       (cnt_inc),
    .bank_ld   (cnt_bank_ld),
    .bank_in   (iBankSel),
    .tap       (cnt_tap),
    .bank      (cnt_bank),
    .last_tap  (cnt_last_tap),
    .last_word (cnt_last_word)
  );

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state_q   <= FIR_SEQ_IDLE;
      addr_q    <= '0;
      wtdt_q    <= '0;
      upd_q     <= 1'b0;
      rd_q      <= 1'b0;
      rdy_q     <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      pending_q <= 1'b0;
      prime_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wtdt_q    <= wtdt_d;
      upd_q     <= upd_d;
      rd_q      <= rd_d;
      rdy_q     <= rdy_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      pending_q <= pending_d;
      prime_q   <= prime_d;
    end
  end

  // All outputs are computed one cycle ahead and registered, so each branch
  // below sets the values the FSM will see during the *next* state.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wtdt_d      = wtdt_q;
    upd_d       = 1'b0;
    rd_d        = 1'b0;
    rdy_d       = 1'b0;
    done_d      = 1'b0;
    pending_d   = pending_q;
    prime_d     = 1'b0;
    drop        = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    cnt_bank_ld = 1'b0;

    unique case (state_q)
      FIR_SEQ_IDLE: begin
        addr_d = '0;
        wtdt_d = '0;
        if (iCoeffLoadReq || pending_q) begin
          // Load wins over a same-cycle strobe, which is then dropped
          state_d   = FIR_SEQ_LOAD;
          pending_d = 1'b0;
          cnt_clr   = 1'b1;
          upd_d     = 1'b1;
          rdy_d     = 1'b1;
          drop      = iEnSample600k;
        end else if (iEnSample600k) begin
          state_d     = FIR_SEQ_READ;
          cnt_clr     = 1'b1;
          cnt_bank_ld = 1'b1;
          addr_d      = pack_addr(iBankSel, '0);
          rd_d        = 1'b1;
          prime_d     = 1'b1;
        end
      end

      FIR_SEQ_LOAD: begin
        drop  = iEnSample600k;
        upd_d = 1'b1;
        rdy_d = 1'b1;
        if (iCoeffVld && rdy_q) begin
          addr_d  = pack_addr(cnt_bank, cnt_tap);
          wtdt_d  = iCoeffDt;
          cnt_inc = 1'b1;
          if (cnt_last_word) begin
            state_d = FIR_SEQ_LOAD_TAIL;
            upd_d   = 1'b0;
            rdy_d   = 1'b0;
          end
        end
      end

      // Address/data of the last word stay put for the FSM's lagging write
      FIR_SEQ_LOAD_TAIL: begin
        drop    = iEnSample600k;
        state_d = FIR_SEQ_IDLE;
        addr_d  = '0;
        wtdt_d  = '0;
      end

      // r0 re-presents tap 0 (prime_q), then taps advance one per cycle and
      // the counter parks on the last tap; once that tap has been shown the
      // sweep ends.
      FIR_SEQ_READ: begin
        drop      = iEnSample600k;
        pending_d = pending_q | iCoeffLoadReq;
        if (!prime_q && addr_q[TAP_W-1:0] == TAP_W'(P_TAPS - 1)) begin
          state_d = FIR_SEQ_DONE;
          done_d  = 1'b1;
        end else begin
          rd_d    = 1'b1;
          addr_d  = pack_addr(cnt_bank, cnt_tap);
          cnt_inc = !cnt_last_tap;
        end
      end

      FIR_SEQ_DONE: begin
        drop      = iEnSample600k;
        pending_d = pending_q | iCoeffLoadReq;
        state_d   = FIR_SEQ_IDLE;
        addr_d    = '0;
        wtdt_d    = '0;
      end

      default: begin
        state_d = FIR_SEQ_IDLE;
        addr_d  = '0;
        wtdt_d  = '0;
      end
    endcase

    ovr_d = drop;
  end

  assign oCoeffRdy        = rdy_q;
  assign oCoeffUpdateFlag = upd_q;
  assign oMemRdFlag       = rd_q;
  assign oAddrRam         = addr_q;
  assign oWtDtRam         = wtdt_q;
  assign oSampleDone      = done_q;
  assign oOverrun         = ovr_q;

`ifdef FIR_SEQ_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn)
      drop_cnt_q <= 8'd0;
    else if (drop && drop_cnt_q != 8'hFF)
      drop_cnt_q <= drop_cnt_q + 8'd1;
  end

  assign oDropCnt = drop_cnt_q;
`else
  assign oDropCnt = 8'd0;
`endif

endmodule

// File: tb/tb_fir_addr_seq.sv
// tb/tb_fir_addr_seq.sv - self-checking bench for fir_addr_seq
module tb_fir_addr_seq;

  localparam int TAPS = 10;
  localparam int NB   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        strobe, load_req, vld;
  logic [1:0]  bank_sel;
  logic [15:0] dt;
  logic        rdy, upd, memrd, done, ovr;
  logic [5:0]  addr;
  logic [15:0] wtdt;
  logic [7:0]  dropcnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fir_addr_seq dut (
    .iClk12M          (clk),
    .iRsn             (rst_n),
    .iEnSample600k    (strobe),
    .iBankSel         (bank_sel),
    .iCoeffLoadReq    (load_req),
    .iCoeffVld        (vld),
    .iCoeffDt         (dt),
    .oCoeffRdy        (rdy),
    .oCoeffUpdateFlag (upd),
    .oMemRdFlag       (memrd),
    .oAddrRam         (addr),
    .oWtDtRam         (wtdt),
    .oSampleDone      (done),
    .oOverrun         (ovr),
    .oDropCnt         (dropcnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int beat_addr(input int j);
    return (j / TAPS) * 16 + (j % TAPS);
  endfunction

  // ---------------- behavioural reference ----------------
  // rd_t : cycles since a read sweep started (-1 none); 0..TAPS flag high, TAPS+1 done cycle
  // ld_k : beats accepted in the current load (-1 none)
  int          m_rd_t = -1, m_rd_bank = 0, m_ld_k = -1, m_drop = 0;
  bit          m_tail = 0, m_pend = 0, m_ovr = 0;
  logic [15:0] m_last_dt = '0;
  logic [15:0] sram [0:63];
  bit          prev_upd = 0;

  task automatic model_step();
    bit d;
    d = 0;
    if (m_rd_t >= 0) begin
      if (load_req) m_pend = 1;
      d = strobe;
      m_rd_t = (m_rd_t == TAPS + 1) ? -1 : m_rd_t + 1;
    end else if (m_ld_k >= 0) begin
      d = strobe;
      if (vld) begin
        m_last_dt = dt;
        m_ld_k++;
        if (m_ld_k == TAPS * NB) begin
          m_ld_k = -1;
          m_tail = 1;
        end
      end
    end else if (m_tail) begin
      d = strobe;
      m_tail = 0;
    end else begin
      if (load_req || m_pend) begin
        m_pend = 0;
        m_ld_k = 0;
        m_last_dt = '0;
        d = strobe;
      end else if (strobe) begin
        m_rd_t = 0;
        m_rd_bank = int'(bank_sel);
      end
    end
    m_ovr = d;
    if (d && m_drop < 255) m_drop++;
  endtask

  task automatic model_check();
    int e_addr;
    logic [15:0] e_dt;
    bit e_upd, e_rdy, e_rd, e_done;
    e_addr = 0; e_dt = '0; e_upd = 0; e_rdy = 0; e_rd = 0; e_done = 0;
    if (m_rd_t >= 0) begin
      e_rd   = (m_rd_t <= TAPS);
      e_done = (m_rd_t == TAPS + 1);
      e_addr = m_rd_bank * 16 + ((m_rd_t == 0) ? 0 : ((m_rd_t <= TAPS) ? m_rd_t - 1 : TAPS - 1));
    end else if (m_ld_k >= 0) begin
      e_upd  = 1;
      e_rdy  = 1;
      e_addr = (m_ld_k == 0) ? 0 : beat_addr(m_ld_k - 1);
      e_dt   = m_last_dt;
    end else if (m_tail) begin
      e_addr = beat_addr(TAPS * NB - 1);
      e_dt   = m_last_dt;
    end
    chk("addr", 32'(addr), 32'(e_addr));
    chk("wtdt", 32'(wtdt), 32'(e_dt));
    chk("upd_flag", 32'(upd), 32'(e_upd));
    chk("rdy", 32'(rdy), 32'(e_rdy));
    chk("memrd_flag", 32'(memrd), 32'(e_rd));
    chk("sample_done", 32'(done), 32'(e_done));
    chk("overrun", 32'(ovr), 32'(m_ovr));
`ifdef FIR_SEQ_DROP_CNT_EN
    chk("drop_cnt", 32'(dropcnt), 32'(m_drop));
`else
    chk("drop_cnt", 32'(dropcnt), 32'd0);
`endif
    chk("flags_exclusive", 32'(upd & memrd), 32'd0);
  endtask

  // Compare process: advance the model on every active edge, check just after.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_rd_t = -1; m_ld_k = -1; m_tail = 0; m_pend = 0;
        m_ovr = 0; m_drop = 0; m_last_dt = '0;
      end else begin
        model_step();
      end
      #1;
      model_check();
      // Shadow of the SRAM as the FSM writes it, one cycle of update lag included
      if (upd || prev_upd) sram[addr] = wtdt;
      prev_upd = upd;
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic feed_load();
    vld = 1'b1;
    for (int k = 0; k < TAPS * NB; k++) begin
      dt = 16'($urandom);
      tick();
    end
    vld = 1'b0;
  endtask

  initial begin
    int n_rd, done_at, lat;
    int seq_addr [0:10];
    int exp_seq  [0:10];

    rst_n = 1'b0; strobe = 0; load_req = 0; vld = 0; bank_sel = 0; dt = '0;
    for (int i = 0; i < 64; i++) sram[i] = '0;
    repeat (3) tick();
    chk("rst_addr", 32'(addr), 0);
    chk("rst_upd", 32'(upd), 0);
    chk("rst_memrd", 32'(memrd), 0);
    chk("rst_rdy", 32'(rdy), 0);
    chk("rst_wtdt", 32'(wtdt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovr", 32'(ovr), 0);
    chk("rst_dropcnt", 32'(dropcnt), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Read sweep on bank 2
    exp_seq[0] = 'h20;
    for (int i = 1; i <= 10; i++) exp_seq[i] = 'h20 + i - 1;
    strobe = 1; bank_sel = 2'd2; tick(); strobe = 0; bank_sel = 0;
    n_rd = 0; done_at = -1;
    for (int i = 0; i < 14; i++) begin
      if (memrd && n_rd < 11) begin seq_addr[n_rd] = int'(addr); n_rd++; end
      if (done && done_at < 0) done_at = i;
      tick();
    end
    chk("read_len", 32'(n_rd), 11);
    chk("read_done_at", 32'(done_at), 11);
    for (int i = 0; i < 11; i++) chk("read_addr_seq", 32'(seq_addr[i]), 32'(exp_seq[i]));

    // Coefficient load, 3-cycle stall at beat 15
    load_req = 1; tick(); load_req = 0;
    chk("load_rdy", 32'(rdy), 1);
    for (int k = 0; k < TAPS * NB; k++) begin
      if (k == 15) begin vld = 0; repeat (3) tick(); end
      vld = 1; dt = 16'(32'h1000 + k); tick();
    end
    vld = 0;
    chk("tail_upd", 32'(upd), 0);
    chk("tail_rdy", 32'(rdy), 0);
    chk("tail_addr", 32'(addr), 'h39);
    chk("tail_wtdt", 32'(wtdt), 'h1027);
    tick();
    chk("post_tail_addr", 32'(addr), 0);
    for (int b = 0; b < NB; b++)
      for (int t = 0; t < TAPS; t++)
        chk("sram_word", 32'(sram[b * 16 + t]), 32'h1000 + 10 * b + t);
    repeat (2) tick();

    // Collision: load and strobe together
    load_req = 1; strobe = 1; tick(); load_req = 0; strobe = 0;
    chk("coll_upd", 32'(upd), 1);
    chk("coll_ovr", 32'(ovr), 1);
    chk("coll_memrd", 32'(memrd), 0);
    feed_load();
    repeat (3) tick();

    // Strobe at r5 is dropped, sweep carries on
    strobe = 1; bank_sel = 2'd1; tick(); strobe = 0;
    repeat (5) tick();
    strobe = 1; tick(); strobe = 0;
    chk("r5_ovr", 32'(ovr), 1);
    chk("r5_memrd", 32'(memrd), 1);
    repeat (12) tick();

    // Pending load raised at r3
    strobe = 1; bank_sel = 2'd3; tick(); strobe = 0;
    repeat (3) tick();
    load_req = 1; tick(); load_req = 0;
    lat = 0;
    while (!upd && lat < 30) begin tick(); lat++; end
    chk("pending_latency", 32'(lat), 9);
    feed_load();
    repeat (3) tick();

    // Asynchronous reset mid-READ
    strobe = 1; bank_sel = 2'd2; tick(); strobe = 0;
    repeat (4) tick();
    rst_n = 0; #1;
    chk("async_rst_memrd", 32'(memrd), 0);
    chk("async_rst_addr", 32'(addr), 0);
    chk("async_rst_done", 32'(done), 0);
    repeat (3) tick();
    rst_n = 1; tick();
    chk("post_rst_addr", 32'(addr), 0);
    chk("post_rst_memrd", 32'(memrd), 0);

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      strobe   = ($urandom % 8) == 0;
      load_req = ($urandom % 64) == 0;
      vld      = ($urandom % 4) != 0;
      dt       = 16'($urandom);
      bank_sel = 2'($urandom);
      tick();
    end
    strobe = 0; load_req = 0; vld = 1;
    repeat (80) tick();
    vld = 0;

    // Many dropped strobes while a load is stalled
    load_req = 1; tick(); load_req = 0;
    strobe = 1;
    repeat (300) tick();
    strobe = 0;
    tick();
`ifdef FIR_SEQ_DROP_CNT_EN
    chk("drop_cnt_sat", 32'(dropcnt), 255);
`else
    chk("drop_cnt_off", 32'(dropcnt), 0);
`endif
    feed_load();
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
